// File: rtl/serial_parity_accumulator_if.sv
// Serial-in bit stream and frame-result handshakes for serial_parity_accumulator.
// The master side feeds bits and takes results; the slave side is the accumulator.
interface serial_parity_accumulator_if #(
  parameter int FRAME_LEN = 8
);
  localparam int CW = $clog2(FRAME_LEN + 1);

  logic          in_valid;
  logic          in_ready;
  logic          in_bit;
  logic          out_valid;
  logic          out_ready;
  logic          out_parity;
  logic [CW-1:0] out_ones;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_parity, out_ones
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_parity, out_ones
  );
endinterface

// File: rtl/serial_parity_accumulator.sv
// XOR-accumulates FRAME_LEN serial bits per frame and holds the frame parity and
// ones-count on a valid/ready output until the consumer takes it.
module serial_parity_accumulator #(
  parameter int FRAME_LEN  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_parity_accumulator_if.slave    bus
);
  localparam int            CW   = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] ones;
  logic [CW-1:0] ones_next;
  logic [CW-1:0] out_ones_q;
  logic          parity;
  logic          parity_next;
  logic          out_parity_q;
  logic          accept;

  assign bus.in_ready   = (state == ACCUM) && !rst;
  assign bus.out_valid  = (state == HOLD);
  assign bus.out_parity = out_parity_q;
  assign bus.out_ones   = out_ones_q;

  assign accept      = bus.in_valid && bus.in_ready;
  assign parity_next = parity ^ bus.in_bit;
  assign ones_next   = ones + CW'(bus.in_bit);

  // The result registers are loaded with the next-state values on the last
  // accept so the final bit is included and out_valid follows one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      count        <= '0;
      parity       <= 1'b0;
      ones         <= '0;
      out_parity_q <= 1'b0;
      out_ones_q   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            parity <= parity_next;
            ones   <= ones_next;
            count  <= count + 1'b1;
            if (count == LAST) begin
              state        <= HOLD;
              out_parity_q <= parity_next ^ ODD_PARITY;
              out_ones_q   <= ones_next;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state  <= ACCUM;
            count  <= '0;
            parity <= 1'b0;
            ones   <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
